// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: functional-unit results,
// common data bus packets and issue-stage stall bundles.
package rv32i_types;

  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int ROB_W  = 4;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_LD  = 2'd3
  } fu_idx_e;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] pd;
    logic [AREG_W-1:0] rd;
    logic [31:0]       data;
    logic [ROB_W-1:0]  rob_idx;
    logic              br_mispred;
  } fu_result_pkt_t;

  typedef struct packed {
    logic              cdb_broadcast;
    logic [PREG_W-1:0] pd;
    logic [AREG_W-1:0] rd;
    logic [31:0]       data;
    logic [ROB_W-1:0]  rob_idx;
    logic              br_mispred;
  } cdb_pkt_t;

  typedef struct packed {
    logic alu_stall;
    logic mul_stall;
    logic div_stall;
    logic br_stall;
  } stall_pkt_t;

  // Map a FIFO head onto a bus packet; mispredict
  // only survives where the caller allows it.
  function automatic cdb_pkt_t to_cdb(
    input fu_result_pkt_t r,
    input logic           keep_mis
  );
    cdb_pkt_t c;
    c.cdb_broadcast = 1'b1;
    c.pd            = r.pd;
    c.rd            = r.rd;
    c.data          = r.data;
    c.rob_idx       = r.rob_idx;
    c.br_mispred    = keep_mis & r.br_mispred;
    return c;
  endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// Per-unit result FIFO: power-of-two depth, naturally
// wrapping pointers, simultaneous push/pop allowed.
module fu_result_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           wen,
  input  fu_result_pkt_t din,
  input  logic           ren,
  output fu_result_pkt_t dout,
  output logic           empty,
  output logic           full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fu_result_pkt_t mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wen & ~full;
  assign pop   = ren & ~empty;
  assign dout  = mem[head];

  // Pointer and occupancy tracking; flush empties in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care outside the live window.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[tail] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus producer: buffers FU results and
// broadcasts up to two per cycle on registered ports.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int FU_BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  fu_result_pkt_t alu_res,
  input  fu_result_pkt_t mul_res,
  input  fu_result_pkt_t div_res,
  input  fu_result_pkt_t br_res,
  input  fu_result_pkt_t ld_res,
  output cdb_pkt_t       cdb_pkt,
  output cdb_pkt_t       cdb_pkt2,
  output stall_pkt_t     f_unit_stalls,
  output logic           ld_unit_stall
);

  fu_result_pkt_t res  [4];
  fu_result_pkt_t head [4];
  fu_result_pkt_t br_head;
  logic [3:0]     empty;
  logic [3:0]     full;
  logic [3:0]     ren;
  logic           br_empty;
  logic           br_full;
  logic           flush;

  logic [1:0]     ptr;
  logic [1:0]     scan;
  logic [1:0]     a_idx;
  logic [1:0]     b_idx;
  logic [1:0]     last;
  logic           a_ok;
  logic           b_ok;
  logic           b_take;

  assign res[FU_ALU] = alu_res;
  assign res[FU_MUL] = mul_res;
  assign res[FU_DIV] = div_res;
  assign res[FU_LD]  = ld_res;

  assign flush = cdb_pkt2.cdb_broadcast & cdb_pkt2.br_mispred;

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    fu_result_fifo #(
      .DEPTH (FU_BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .wen   (res[g].valid),
      .din   (res[g]),
      .ren   (ren[g]),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  fu_result_fifo #(
    .DEPTH (FU_BUF_DEPTH)
  ) u_br_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .wen   (br_res.valid),
    .din   (br_res),
    .ren   (~br_empty),
    .dout  (br_head),
    .empty (br_empty),
    .full  (br_full)
  );

  assign f_unit_stalls.alu_stall = full[FU_ALU];
  assign f_unit_stalls.mul_stall = full[FU_MUL];
  assign f_unit_stalls.div_stall = full[FU_DIV];
  assign f_unit_stalls.br_stall  = br_full;
  assign ld_unit_stall           = full[FU_LD];

  // Round-robin scan from ptr: first hit feeds port A, second is port B overflow.
  always_comb begin
    a_ok  = 1'b0;
    b_ok  = 1'b0;
    a_idx = ptr;
    b_idx = ptr;
    scan  = ptr;
    for (int i = 0; i < 4; i++) begin
      scan = ptr + 2'(i);
      if (!empty[scan]) begin
        if (!a_ok) begin
          a_ok  = 1'b1;
          a_idx = scan;
        end else if (!b_ok) begin
          b_ok  = 1'b1;
          b_idx = scan;
        end
      end
    end
  end

  assign b_take = b_ok & br_empty;
  assign last   = b_take ? b_idx : a_idx;

  // Pop every head that wins a port this cycle.
  always_comb begin
    ren = '0;
    if (a_ok)   ren[a_idx] = 1'b1;
    if (b_take) ren[b_idx] = 1'b1;
  end

  // Output flops and RR pointer; a mispredict on port B wipes everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_pkt  <= '0;
      cdb_pkt2 <= '0;
      ptr      <= FU_ALU;
    end else begin
      cdb_pkt <= a_ok ? to_cdb(head[a_idx], 1'b0) : '0;
      if (!br_empty)   cdb_pkt2 <= to_cdb(br_head, 1'b1);
      else if (b_ok)   cdb_pkt2 <= to_cdb(head[b_idx], 1'b0);
      else             cdb_pkt2 <= '0;
      if (a_ok) ptr <= last + 2'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random
// traffic scored against a queue-based reference model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  fu_result_pkt_t alu_res = '0;
  fu_result_pkt_t mul_res = '0;
  fu_result_pkt_t div_res = '0;
  fu_result_pkt_t br_res  = '0;
  fu_result_pkt_t ld_res  = '0;
  cdb_pkt_t       cdb_pkt;
  cdb_pkt_t       cdb_pkt2;
  stall_pkt_t     f_unit_stalls;
  logic           ld_unit_stall;

  always #5 clk = ~clk;

  cdb_arbiter #(.FU_BUF_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_res       (alu_res),
    .mul_res       (mul_res),
    .div_res       (div_res),
    .br_res        (br_res),
    .ld_res        (ld_res),
    .cdb_pkt       (cdb_pkt),
    .cdb_pkt2      (cdb_pkt2),
    .f_unit_stalls (f_unit_stalls),
    .ld_unit_stall (ld_unit_stall)
  );

  int checks = 0;
  int passes = 0;
  int seq    = 0;
  int mul_stall_seen;

  // Reference: 0 ALU, 1 MUL, 2 DIV, 3 LD, 4 BR
  fu_result_pkt_t q [5][$];
  cdb_pkt_t       exp_a = '0;
  cdb_pkt_t       exp_b = '0;
  int             rr = 0;

  function automatic cdb_pkt_t bus(fu_result_pkt_t r, bit is_br);
    cdb_pkt_t c;
    c = '0;
    c.cdb_broadcast = 1'b1;
    c.pd      = r.pd;
    c.rd      = r.rd;
    c.data    = r.data;
    c.rob_idx = r.rob_idx;
    c.br_mispred = is_br ? r.br_mispred : 1'b0;
    return c;
  endfunction

  function automatic fu_result_pkt_t pk(bit v, bit mis);
    fu_result_pkt_t r;
    seq++;
    r.valid      = v;
    r.pd         = 6'($urandom);
    r.rd         = 5'($urandom);
    r.data       = $urandom;
    r.rob_idx    = 4'(seq);
    r.br_mispred = mis;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 5; i++) q[i].delete();
    exp_a = '0;
    exp_b = '0;
    rr    = 0;
  endtask

  task automatic model_step();
    fu_result_pkt_t inq [5];
    bit  was_full [5];
    int  order[$];
    int  last;
    cdb_pkt_t na, nb;
    inq[0] = alu_res; inq[1] = mul_res; inq[2] = div_res;
    inq[3] = ld_res;  inq[4] = br_res;
    if (rst || (exp_b.cdb_broadcast && exp_b.br_mispred)) begin
      clear_model();
      return;
    end
    for (int i = 0; i < 5; i++) was_full[i] = (q[i].size() == D);
    for (int k = 0; k < 4; k++)
      if (q[(rr + k) % 4].size() > 0) order.push_back((rr + k) % 4);
    na = '0;
    nb = '0;
    last = rr;
    if (order.size() > 0) begin
      na   = bus(q[order[0]].pop_front(), 1'b0);
      last = order[0];
    end
    if (q[4].size() > 0) begin
      nb = bus(q[4].pop_front(), 1'b1);
    end else if (order.size() > 1) begin
      nb   = bus(q[order[1]].pop_front(), 1'b0);
      last = order[1];
    end
    if (order.size() > 0) rr = (last + 1) % 4;
    for (int i = 0; i < 5; i++)
      if (inq[i].valid && !was_full[i]) q[i].push_back(inq[i]);
    exp_a = na;
    exp_b = nb;
  endtask

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) passes++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
  endtask

  task automatic check_all(string tag);
    logic [3:0] es;
    es = {q[0].size() == D, q[1].size() == D,
          q[2].size() == D, q[4].size() == D};
    chk({tag, ".a"},   64'(cdb_pkt),       64'(exp_a));
    chk({tag, ".b"},   64'(cdb_pkt2),      64'(exp_b));
    chk({tag, ".stl"}, 64'(f_unit_stalls), 64'(es));
    chk({tag, ".ld"},  64'(ld_unit_stall), 64'(q[3].size() == D));
  endtask

  // Requested valids are masked by the unit's stall.
  task automatic set_in(bit va, bit vm, bit vd, bit vl, bit vb, bit mis);
    alu_res = pk(va && q[0].size() < D, 1'($urandom));
    mul_res = pk(vm && q[1].size() < D, 1'($urandom));
    div_res = pk(vd && q[2].size() < D, 1'($urandom));
    ld_res  = pk(vl && q[3].size() < D, 1'($urandom));
    br_res  = pk(vb && q[4].size() < D, mis);
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    tick("rst");
    rst = 1'b0;
  endtask

  fu_result_pkt_t sa, sm, sd, sl, sb;

  initial begin
    // 1: reset then idle
    do_reset();
    for (int i = 0; i < 5; i++) tick("idle");
    chk("t1.abc", 64'(cdb_pkt.cdb_broadcast), 64'(0));
    chk("t1.bbc", 64'(cdb_pkt2.cdb_broadcast), 64'(0));

    // 2: single ALU result, two-cycle latency
    set_in(0, 0, 0, 0, 0, 0);
    alu_res.valid = 1'b1;
    alu_res.pd    = 6'd7;
    alu_res.data  = 32'h11;
    alu_res.br_mispred = 1'b1;
    tick("t2.c1");
    chk("t2.early", 64'(cdb_pkt.cdb_broadcast), 64'(0));
    set_in(0, 0, 0, 0, 0, 0);
    tick("t2.c2");
    chk("t2.pd",   64'(cdb_pkt.pd),   64'(7));
    chk("t2.data", 64'(cdb_pkt.data), 64'(32'h11));
    chk("t2.mis",  64'(cdb_pkt.br_mispred), 64'(0));
    chk("t2.b",    64'(cdb_pkt2.cdb_broadcast), 64'(0));

    // 3: four non-BR units at once
    do_reset();
    set_in(1, 1, 1, 1, 0, 0);
    sa = alu_res; sm = mul_res; sd = div_res; sl = ld_res;
    tick("t3.c1");
    set_in(0, 0, 0, 0, 0, 0);
    tick("t3.c2");
    chk("t3.a0", 64'(cdb_pkt.rob_idx),  64'(sa.rob_idx));
    chk("t3.b0", 64'(cdb_pkt2.rob_idx), 64'(sm.rob_idx));
    tick("t3.c3");
    chk("t3.a1", 64'(cdb_pkt.rob_idx),  64'(sd.rob_idx));
    chk("t3.b1", 64'(cdb_pkt2.rob_idx), 64'(sl.rob_idx));
    // pointer back at ALU: ALU beats LD
    set_in(1, 0, 0, 1, 0, 0);
    sa = alu_res; sl = ld_res;
    tick("t3.c4");
    set_in(0, 0, 0, 0, 0, 0);
    tick("t3.c5");
    chk("t3.ptr", 64'(cdb_pkt.rob_idx), 64'(sa.rob_idx));

    // 4: BR takes port B, never port A
    do_reset();
    set_in(1, 1, 0, 0, 1, 0);
    sa = alu_res; sm = mul_res; sb = br_res;
    tick("t4.c1");
    set_in(0, 0, 0, 0, 0, 0);
    tick("t4.c2");
    chk("t4.b0", 64'(cdb_pkt2.rob_idx), 64'(sb.rob_idx));
    chk("t4.a0", 64'(cdb_pkt.rob_idx),  64'(sa.rob_idx));
    tick("t4.c3");
    chk("t4.a1", 64'(cdb_pkt.rob_idx),  64'(sm.rob_idx));
    chk("t4.b1", 64'(cdb_pkt2.cdb_broadcast), 64'(0));

    // 5: MUL backs up behind BR/ALU/DIV/LD traffic
    do_reset();
    mul_stall_seen = 0;
    begin
      int sent = 0;
      for (int c = 0; c < 12; c++) begin
        set_in(1, sent < 3, 1, 1, 1, 0);
        if (mul_res.valid) sent++;
        tick("t5");
        if (f_unit_stalls.mul_stall) mul_stall_seen++;
      end
      chk("t5.sent", 64'(sent), 64'(3));
    end
    chk("t5.stall", 64'(mul_stall_seen > 0), 64'(1));
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick("t5.drain");

    // 6: mispredict flush with DIV/LD queued
    do_reset();
    set_in(0, 0, 1, 1, 1, 1);
    tick("t6.c1");
    set_in(0, 0, 1, 1, 0, 0);
    tick("t6.c2");
    chk("t6.mis",  64'(cdb_pkt2.br_mispred), 64'(1));
    chk("t6.abc",  64'(cdb_pkt.cdb_broadcast), 64'(1));
    chk("t6.ldst", 64'(ld_unit_stall), 64'(1));
    set_in(1, 0, 0, 0, 0, 0);
    tick("t6.c3");
    chk("t6.a",   64'(cdb_pkt),  64'(0));
    chk("t6.b",   64'(cdb_pkt2), 64'(0));
    chk("t6.stl", 64'({f_unit_stalls, ld_unit_stall}), 64'(0));
    set_in(0, 0, 0, 0, 0, 0);
    tick("t6.c4");
    chk("t6.drop", 64'(cdb_pkt.cdb_broadcast), 64'(0));

    // Random traffic, occasional mid-run reset
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 150) == 0);
      set_in($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      tick("rnd");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
